lsu_stage: RTL and testbench

- Parametrised load/store pipeline stage. It sits between execute and writeback and succeeds the fixed 32-bit memory stage.
- Adds the following over that stage:
  - configurable data width (32/64);
  - byte-lane strobes and sub-word alignment;
  - misaligned and illegal-width detection;
  - a decoupled memory request/response handshake;
  - a registered output with valid/ready.
- Non-memory ops pass through with one cycle of latency.

---
 rtl/lsu_stage.sv | 198 +++++++++++++++++++
 tb/tb_lsu_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_stage.sv
// Load/store pipeline stage: decodes size/alignment, issues a decoupled memory
// request, aligns the response and presents a registered valid/ready result.
module lsu_stage #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_IDX_WIDTH  = 5,
  parameter int unsigned SIDEBAND_WIDTH = 48
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_load,
  input  logic                        in_store,
  input  logic [2:0]                  in_funct3,
  input  logic [ADDR_WIDTH-1:0]       in_addr,
  input  logic [DATA_WIDTH-1:0]       in_store_data,
  input  logic [REG_IDX_WIDTH-1:0]    in_rd,
  input  logic                        in_wb_en,
  input  logic [SIDEBAND_WIDTH-1:0]   in_sideband,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_result,
  output logic [REG_IDX_WIDTH-1:0]    out_rd,
  output logic                        out_wb_en,
  output logic [SIDEBAND_WIDTH-1:0]   out_sideband,
  output logic                        out_misaligned,
  output logic                        out_illegal,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic                        mem_req_write,
  output logic [ADDR_WIDTH-1:0]       mem_req_addr,
  output logic [DATA_WIDTH-1:0]       mem_req_wdata,
  output logic [DATA_WIDTH/8-1:0]     mem_req_strb,
  input  logic                        mem_rsp_valid,
  output logic                        mem_rsp_ready,
  input  logic [DATA_WIDTH-1:0]       mem_rsp_rdata
);

  localparam int unsigned STRBW = DATA_WIDTH / 8;
  localparam int unsigned OFFW  = $clog2(STRBW);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  state_t                      r_state, w_state_nxt;
  logic                        r_out_valid, r_out_misaligned, r_out_illegal;
  logic [DATA_WIDTH-1:0]       r_out_result;
  logic [REG_IDX_WIDTH-1:0]    r_out_rd;
  logic                        r_out_wb_en;
  logic [SIDEBAND_WIDTH-1:0]   r_out_sideband;

  logic                        r_req_write;
  logic [ADDR_WIDTH-1:0]       r_req_addr;
  logic [DATA_WIDTH-1:0]       r_req_wdata;
  logic [STRBW-1:0]            r_req_strb;
  logic [OFFW-1:0]             r_off;
  logic [2:0]                  r_funct3;
  logic [3:0]                  r_nbytes;
  logic [REG_IDX_WIDTH-1:0]    r_rd;
  logic                        r_wb_en;
  logic [SIDEBAND_WIDTH-1:0]   r_sideband;

  logic [3:0]                  w_nbytes;
  logic                        w_f3_legal, w_addr_mis, w_mem_op;
  logic                        w_illegal, w_misaligned;
  logic                        w_out_free, w_accept, w_fast, w_start;
  logic                        w_rsp_ready, w_rsp_fire, w_out_load;
  logic [OFFW-1:0]             w_off;
  logic [STRBW-1:0]            w_mask, w_strb;
  logic [DATA_WIDTH-1:0]       w_wshift, w_wdata;
  logic [DATA_WIDTH-1:0]       w_rshift, w_ld;
  logic                        w_sbit;
  logic [DATA_WIDTH-1:0]       w_addr_ext;

  always_comb begin
    w_nbytes   = 4'd1;
    w_f3_legal = 1'b0;
    case (in_funct3)
      3'd0, 3'd4: begin w_nbytes = 4'd1; w_f3_legal = 1'b1; end
      3'd1, 3'd5: begin w_nbytes = 4'd2; w_f3_legal = 1'b1; end
      3'd2:       begin w_nbytes = 4'd4; w_f3_legal = 1'b1; end
      3'd6:       begin w_nbytes = 4'd4; w_f3_legal = (DATA_WIDTH == 64); end
      3'd3:       begin w_nbytes = 4'd8; w_f3_legal = (DATA_WIDTH == 64); end
      default:    begin w_nbytes = 4'd1; w_f3_legal = 1'b0; end
    endcase
  end

  // Size is a power of two, so (size-1) masks the low address bits; 8 wraps to 7.
  assign w_addr_mis   = (in_addr[2:0] & (w_nbytes[2:0] - 3'd1)) != 3'd0;
  assign w_mem_op     = in_load | in_store;
  assign w_illegal    = w_mem_op && !w_f3_legal;
  assign w_misaligned = w_mem_op && w_f3_legal && w_addr_mis;
  assign w_off        = in_addr[OFFW-1:0];
  assign w_addr_ext   = DATA_WIDTH'(in_addr);

  assign w_out_free = !r_out_valid || out_ready;
  assign in_ready   = (r_state == IDLE) && w_out_free;
  assign w_accept   = in_valid && in_ready;
  assign w_fast     = w_accept && (!w_mem_op || w_illegal || w_misaligned);
  assign w_start    = w_accept && w_mem_op && !w_illegal && !w_misaligned;

  assign w_rsp_ready = (r_state == RSP) && w_out_free;
  assign w_rsp_fire  = w_rsp_ready && mem_rsp_valid;
  assign w_out_load  = w_fast || w_rsp_fire;

  always_comb begin
    w_mask = '0;
    for (int unsigned i = 0; i < STRBW; i++) w_mask[i] = (i < 32'(w_nbytes));
    w_strb   = w_mask << w_off;
    w_wshift = in_store_data << {w_off, 3'b000};
    w_wdata  = '0;
    for (int unsigned i = 0; i < STRBW; i++)
      if (w_strb[i]) w_wdata[8*i +: 8] = w_wshift[8*i +: 8];
  end

  always_comb begin
    w_rshift = mem_rsp_rdata >> {r_off, 3'b000};
    case (r_funct3[1:0])
      2'd0:    w_sbit = w_rshift[7];
      2'd1:    w_sbit = w_rshift[15];
      2'd2:    w_sbit = w_rshift[31];
      default: w_sbit = w_rshift[DATA_WIDTH-1];
    endcase
    w_ld = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++)
      w_ld[i] = (i < 32'(r_nbytes) * 32'd8) ? w_rshift[i] : (!r_funct3[2] && w_sbit);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_nxt = REQ;
      REQ:     if (mem_req_ready) w_state_nxt = RSP;
      RSP:     if (w_rsp_fire) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= IDLE;
      r_out_valid      <= 1'b0;
      r_out_misaligned <= 1'b0;
      r_out_illegal    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_out_load) begin
        r_out_valid      <= 1'b1;
        r_out_misaligned <= w_fast && w_misaligned;
        r_out_illegal    <= w_fast && w_illegal;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Payload registers need no reset: valid/state gate every use of them.
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_req_write <= in_store;
      r_req_addr  <= in_addr & ~ADDR_WIDTH'(STRBW - 1);
      r_req_wdata <= w_wdata;
      r_req_strb  <= w_strb;
      r_off       <= w_off;
      r_funct3    <= in_funct3;
      r_nbytes    <= w_nbytes;
      r_rd        <= in_rd;
      r_wb_en     <= in_wb_en;
      r_sideband  <= in_sideband;
    end
    if (w_fast) begin
      r_out_result   <= w_addr_ext;
      r_out_wb_en    <= in_wb_en && !w_illegal && !w_misaligned;
      r_out_rd       <= in_rd;
      r_out_sideband <= in_sideband;
    end else if (w_rsp_fire) begin
      r_out_result   <= r_req_write ? '0 : w_ld;
      r_out_wb_en    <= r_wb_en && !r_req_write;
      r_out_rd       <= r_rd;
      r_out_sideband <= r_sideband;
    end
  end

  assign out_valid      = r_out_valid;
  assign out_result     = r_out_result;
  assign out_rd         = r_out_rd;
  assign out_wb_en      = r_out_wb_en;
  assign out_sideband   = r_out_sideband;
  assign out_misaligned = r_out_misaligned;
  assign out_illegal    = r_out_illegal;
  assign mem_req_valid  = (r_state == REQ);
  assign mem_req_write  = r_req_write;
  assign mem_req_addr   = r_req_addr;
  assign mem_req_wdata  = r_req_wdata;
  assign mem_req_strb   = r_req_strb;
  assign mem_rsp_ready  = w_rsp_ready;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage: 32-bit instance for pass-through, sub-word,
// fault and reset cases; 64-bit instance for backpressure and wide loads.
module tb_lsu_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        a_in_valid, a_in_ready, a_in_load, a_in_store, a_in_wb_en;
  logic [2:0]  a_in_funct3;
  logic [31:0] a_in_addr, a_in_store_data, a_out_result;
  logic [4:0]  a_in_rd, a_out_rd;
  logic [47:0] a_in_sideband, a_out_sideband;
  logic        a_out_valid, a_out_ready, a_out_wb_en, a_out_mis, a_out_ill;
  logic        a_req_valid, a_req_ready, a_req_write, a_rsp_valid, a_rsp_ready;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic [3:0]  a_req_strb;

  logic        b_in_valid, b_in_ready, b_in_load, b_in_store, b_in_wb_en;
  logic [2:0]  b_in_funct3;
  logic [31:0] b_in_addr, b_req_addr;
  logic [63:0] b_in_store_data, b_out_result, b_req_wdata, b_rsp_rdata;
  logic [4:0]  b_in_rd, b_out_rd;
  logic [47:0] b_in_sideband, b_out_sideband;
  logic        b_out_valid, b_out_ready, b_out_wb_en, b_out_mis, b_out_ill;
  logic        b_req_valid, b_req_ready, b_req_write, b_rsp_valid, b_rsp_ready;
  logic [7:0]  b_req_strb;

  lsu_stage #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_IDX_WIDTH(5), .SIDEBAND_WIDTH(48)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_load(a_in_load), .in_store(a_in_store), .in_funct3(a_in_funct3), .in_addr(a_in_addr),
    .in_store_data(a_in_store_data), .in_rd(a_in_rd), .in_wb_en(a_in_wb_en),
    .in_sideband(a_in_sideband), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_result(a_out_result), .out_rd(a_out_rd), .out_wb_en(a_out_wb_en),
    .out_sideband(a_out_sideband), .out_misaligned(a_out_mis), .out_illegal(a_out_ill),
    .mem_req_valid(a_req_valid), .mem_req_ready(a_req_ready), .mem_req_write(a_req_write),
    .mem_req_addr(a_req_addr), .mem_req_wdata(a_req_wdata), .mem_req_strb(a_req_strb),
    .mem_rsp_valid(a_rsp_valid), .mem_rsp_ready(a_rsp_ready), .mem_rsp_rdata(a_rsp_rdata));

  lsu_stage #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .REG_IDX_WIDTH(5), .SIDEBAND_WIDTH(48)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_load(b_in_load), .in_store(b_in_store), .in_funct3(b_in_funct3), .in_addr(b_in_addr),
    .in_store_data(b_in_store_data), .in_rd(b_in_rd), .in_wb_en(b_in_wb_en),
    .in_sideband(b_in_sideband), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_result(b_out_result), .out_rd(b_out_rd), .out_wb_en(b_out_wb_en),
    .out_sideband(b_out_sideband), .out_misaligned(b_out_mis), .out_illegal(b_out_ill),
    .mem_req_valid(b_req_valid), .mem_req_ready(b_req_ready), .mem_req_write(b_req_write),
    .mem_req_addr(b_req_addr), .mem_req_wdata(b_req_wdata), .mem_req_strb(b_req_strb),
    .mem_rsp_valid(b_rsp_valid), .mem_rsp_ready(b_rsp_ready), .mem_rsp_rdata(b_rsp_rdata));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full 32-bit memory access with a zero-wait memory.
  task automatic mem32(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] rdata,
                       input logic [3:0] estrb, input logic [31:0] ewdata,
                       input logic [31:0] eres, input logic ewb);
    a_in_valid = 1; a_in_load = ld; a_in_store = st; a_in_funct3 = f3;
    a_in_addr = addr; a_in_store_data = sdata; a_in_rd = 5'd7; a_in_wb_en = 1;
    chk({tag, ".in_ready"}, 64'(a_in_ready), 64'd1);
    tick();
    a_in_valid = 0; a_in_load = 0; a_in_store = 0;
    chk({tag, ".req_valid"}, 64'(a_req_valid), 64'd1);
    chk({tag, ".req_addr"}, 64'(a_req_addr), 64'(addr & 32'hFFFF_FFFC));
    chk({tag, ".req_strb"}, 64'(a_req_strb), 64'(estrb));
    chk({tag, ".req_wdata"}, 64'(a_req_wdata), 64'(ewdata));
    chk({tag, ".req_write"}, 64'(a_req_write), 64'(st));
    chk({tag, ".in_ready_busy"}, 64'(a_in_ready), 64'd0);
    tick();
    chk({tag, ".rsp_state_req"}, 64'(a_req_valid), 64'd0);
    chk({tag, ".rsp_ready"}, 64'(a_rsp_ready), 64'd1);
    chk({tag, ".no_early_out"}, 64'(a_out_valid), 64'd0);
    a_rsp_valid = 1; a_rsp_rdata = rdata;
    tick();
    a_rsp_valid = 0;
    chk({tag, ".out_valid"}, 64'(a_out_valid), 64'd1);
    chk({tag, ".out_result"}, 64'(a_out_result), 64'(eres));
    chk({tag, ".out_wb_en"}, 64'(a_out_wb_en), 64'(ewb));
    chk({tag, ".out_rd"}, 64'(a_out_rd), 64'd7);
    chk({tag, ".flags"}, 64'({a_out_mis, a_out_ill}), 64'd0);
  endtask

  task automatic mem64_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [63:0] rdata, input logic [7:0] estrb,
                            input logic [63:0] eres);
    b_in_valid = 1; b_in_load = 1; b_in_funct3 = f3; b_in_addr = addr;
    tick();
    b_in_valid = 0; b_in_load = 0;
    chk({tag, ".req_strb"}, 64'(b_req_strb), 64'(estrb));
    chk({tag, ".req_addr"}, 64'(b_req_addr), 64'(addr & 32'hFFFF_FFF8));
    tick();
    b_rsp_valid = 1; b_rsp_rdata = rdata;
    tick();
    b_rsp_valid = 0;
    chk({tag, ".out_valid"}, 64'(b_out_valid), 64'd1);
    chk({tag, ".out_result"}, b_out_result, eres);
  endtask

  initial begin
    rst_n = 0;
    a_in_valid = 0; a_in_load = 0; a_in_store = 0; a_in_funct3 = 0; a_in_addr = 0;
    a_in_store_data = 0; a_in_rd = 0; a_in_wb_en = 0; a_in_sideband = 0;
    a_out_ready = 1; a_req_ready = 1; a_rsp_valid = 0; a_rsp_rdata = 0;
    b_in_valid = 0; b_in_load = 0; b_in_store = 0; b_in_funct3 = 0; b_in_addr = 0;
    b_in_store_data = 0; b_in_rd = 0; b_in_wb_en = 0; b_in_sideband = 0;
    b_out_ready = 1; b_req_ready = 1; b_rsp_valid = 0; b_rsp_rdata = 0;
    #1;
    chk("rst.out_valid", 64'(a_out_valid), 64'd0);
    chk("rst.req_valid", 64'(a_req_valid), 64'd0);
    chk("rst.rsp_ready", 64'(a_rsp_ready), 64'd0);
    chk("rst.flags", 64'({a_out_mis, a_out_ill}), 64'd0);
    chk("rst.in_ready", 64'(a_in_ready), 64'd1);
    tick(); tick();
    rst_n = 1;
    tick();

    // Pass-through: one op per cycle, one cycle of latency
    for (int k = 0; k < 4; k++) begin
      a_in_valid = 1; a_in_addr = 32'h1234 + 32'(k); a_in_rd = 5'(k + 1);
      a_in_wb_en = 1; a_in_sideband = 48'hABC000 + 48'(k);
      chk("pt.in_ready", 64'(a_in_ready), 64'd1);
      tick();
      chk("pt.out_valid", 64'(a_out_valid), 64'd1);
      chk("pt.out_result", 64'(a_out_result), 64'(32'h1234 + 32'(k)));
      chk("pt.out_rd", 64'(a_out_rd), 64'(k + 1));
      chk("pt.sideband", 64'(a_out_sideband), 64'(48'hABC000 + 48'(k)));
      chk("pt.wb_en", 64'(a_out_wb_en), 64'd1);
      chk("pt.no_req", 64'(a_req_valid), 64'd0);
    end
    a_in_valid = 0;
    tick();
    chk("pt.drain", 64'(a_out_valid), 64'd0);

    mem32("lb",  1, 0, 3'd0, 32'h1003, 32'h0, 32'h80FF_0000, 4'b1000, 32'h0, 32'hFFFF_FF80, 1);
    mem32("lbu", 1, 0, 3'd4, 32'h1003, 32'h0, 32'h80FF_0000, 4'b1000, 32'h0, 32'h0000_0080, 1);
    mem32("sh",  0, 1, 3'd1, 32'h2002, 32'h1234_ABCD, 32'hDEAD_BEEF, 4'b1100, 32'hABCD_0000, 32'h0, 0);
    mem32("lh",  1, 0, 3'd1, 32'h2002, 32'h0, 32'h8001_7FFF, 4'b1100, 32'h0, 32'hFFFF_8001, 1);

    // Faults: no memory request, flags set, fault address returned
    a_in_valid = 1; a_in_load = 1; a_in_funct3 = 3'd2; a_in_addr = 32'h3001; a_in_wb_en = 1;
    tick();
    a_in_valid = 0; a_in_load = 0;
    chk("mis.flag", 64'(a_out_mis), 64'd1);
    chk("mis.ill", 64'(a_out_ill), 64'd0);
    chk("mis.result", 64'(a_out_result), 64'h3001);
    chk("mis.wb_en", 64'(a_out_wb_en), 64'd0);
    chk("mis.no_req", 64'(a_req_valid), 64'd0);
    tick();
    chk("mis.no_req_later", 64'(a_req_valid), 64'd0);
    chk("mis.drain", 64'(a_out_valid), 64'd0);

    a_in_valid = 1; a_in_load = 1; a_in_funct3 = 3'd3; a_in_addr = 32'h3008;
    tick();
    a_in_valid = 0; a_in_load = 0;
    chk("ill_d32.flag", 64'({a_out_ill, a_out_mis}), 64'b10);
    chk("ill_d32.no_req", 64'(a_req_valid), 64'd0);
    a_in_valid = 1; a_in_store = 1; a_in_funct3 = 3'd7; a_in_addr = 32'h3001;
    tick();
    a_in_valid = 0; a_in_store = 0;
    chk("ill_mis.flags", 64'({a_out_ill, a_out_mis}), 64'b10);
    chk("ill_mis.result", 64'(a_out_result), 64'h3001);
    tick();

    // 64-bit backpressure on both the request and the output
    b_out_ready = 0; b_req_ready = 0;
    b_in_valid = 1; b_in_load = 1; b_in_funct3 = 3'd6; b_in_addr = 32'h4004;
    b_in_rd = 5'd9; b_in_wb_en = 1;
    tick();
    b_in_valid = 0; b_in_load = 0;
    for (int i = 0; i < 4; i++) begin
      chk("bp.req_valid", 64'(b_req_valid), 64'd1);
      chk("bp.req_addr", 64'(b_req_addr), 64'h4000);
      chk("bp.req_strb", 64'(b_req_strb), 64'hF0);
      chk("bp.in_ready", 64'(b_in_ready), 64'd0);
      if (i == 3) b_req_ready = 1;
      tick();
    end
    chk("bp.rsp_ready", 64'(b_rsp_ready), 64'd1);
    b_rsp_valid = 1; b_rsp_rdata = 64'h8000_0001_DEAD_BEEF;
    tick();
    b_rsp_valid = 0;
    for (int i = 0; i < 5; i++) begin
      chk("bp.out_valid", 64'(b_out_valid), 64'd1);
      chk("bp.out_result", b_out_result, 64'h0000_0000_8000_0001);
      chk("bp.out_rd", 64'(b_out_rd), 64'd9);
      chk("bp.in_ready_out", 64'(b_in_ready), 64'd0);
      tick();
    end
    b_out_ready = 1;
    #1;
    chk("bp.in_ready_free", 64'(b_in_ready), 64'd1);
    tick();
    chk("bp.drain", 64'(b_out_valid), 64'd0);

    mem64_load("lw64", 3'd2, 32'h4004, 64'h8000_0001_DEAD_BEEF, 8'hF0, 64'hFFFF_FFFF_8000_0001);
    mem64_load("ld64", 3'd3, 32'h4008, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0123_4567_89AB_CDEF);
    mem64_load("lh64", 3'd1, 32'h4006, 64'h8001_2345_6789_ABCD, 8'hC0, 64'hFFFF_FFFF_FFFF_8001);
    tick();

    // Reset while waiting in RSP, then a stale response must be ignored
    a_in_valid = 1; a_in_load = 1; a_in_funct3 = 3'd0; a_in_addr = 32'h1003;
    tick();
    a_in_valid = 0; a_in_load = 0;
    tick();
    chk("rrsp.rsp_ready", 64'(a_rsp_ready), 64'd1);
    #2 rst_n = 0;
    #1;
    chk("rrsp.rsp_ready_rst", 64'(a_rsp_ready), 64'd0);
    chk("rrsp.req_valid_rst", 64'(a_req_valid), 64'd0);
    chk("rrsp.out_valid_rst", 64'(a_out_valid), 64'd0);
    tick();
    rst_n = 1;
    a_rsp_valid = 1; a_rsp_rdata = 32'h1122_3344;
    #1;
    chk("rrsp.stale_ready", 64'(a_rsp_ready), 64'd0);
    tick();
    a_rsp_valid = 0;
    chk("rrsp.stale_out", 64'(a_out_valid), 64'd0);
    mem32("post_rst", 1, 0, 3'd4, 32'h1001, 32'h0, 32'h0000_5A00, 4'b0010, 32'h0, 32'h0000_005A, 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
